start_seq_arb: RTL and testbench
================================

START_SEQ_ARB -- requirements
Module: start_seq_arb

Interface
REQ-001 Parameter GAP_CYCLES, default 2, meaning idle cycles enforced after each transaction (legal 0..15).
REQ-002 Parameter CNT_W, default 8, meaning width of the completed-transaction counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-005 req  input  2  level request per requester; held until that requester's done pulse.
REQ-006 gnt  output 2  one-hot grant, held from START through DRIVE.
REQ-007 start  output 1  one-cycle start pulse to the shared resource.
REQ-008 a  output 1  resource qualifier a.
REQ-009 b  output 1  resource qualifier b.
REQ-010 done  output 2  one-hot one-cycle completion pulse to the granted requester.
REQ-011 busy  output 1  high in any state other than IDLE.
REQ-012 txn_cnt  output CNT_W  count of completed transactions.

Function
REQ-013 FSM states SHALL be IDLE, START, DRIVE, GAP; all outputs SHALL be registered or decoded from registered state only.
REQ-014 IDLE: when req!=0 at a posedge, SHALL move to START and latch the winner into gnt; req==0 stays IDLE.
REQ-015 Arbitration SHALL be round-robin: single request wins; with req==2'b11 the requester not granted last wins.
REQ-016 Last-grant pointer SHALL reset to requester 1, so requester 0 wins the first contention.
REQ-017 START: start=1 for exactly one cycle, a=b=0; next state DRIVE unconditionally.
REQ-018 DRIVE: a=1 and b=1 for exactly one cycle, start=0, done[winner]=1; guarantees $rose(start) |-> ##1 (a && b).
REQ-019 On leaving DRIVE, txn_cnt SHALL increment by 1, wrapping from all-ones to 0 without flag.
REQ-020 DRIVE exit: GAP_CYCLES==0 -> IDLE; otherwise GAP for exactly GAP_CYCLES cycles (down-counter), then IDLE.
REQ-021 gnt SHALL be 0 in IDLE and GAP; start, a, b, done SHALL be 0 outside their states.
REQ-022 Requests arriving or dropping during START/DRIVE/GAP SHALL not alter the current transaction; a request dropped before DRIVE still completes.
REQ-023 Minimum request-to-request spacing SHALL be 3+GAP_CYCLES cycles (IDLE sample, START, DRIVE, GAP).
REQ-024 Requests still asserted on return to IDLE SHALL be re-arbitrated that cycle using the updated pointer.

Reset
REQ-025 On rst==0, asynchronously: state=IDLE, gnt=0, start=0, a=0, b=0, done=0, busy=0, txn_cnt=0, gap counter=0, pointer=1.
REQ-026 Reset mid-transaction SHALL abort without a done pulse and without txn_cnt increment.
REQ-027 First arbitration SHALL occur at the first posedge after rst rises.

Structure
REQ-028 State enum (IDLE, START, DRIVE, GAP) and GAP_CYCLES default SHALL live in shared package start_seq_pkg.
REQ-029 Round-robin selection SHALL be sub-module rr_arb2 (inputs req, last pointer; output one-hot winner), purely combinational.
REQ-030 Checker for REQ-018 and one-hot gnt/done SHALL be bound from the bench, not embedded in RTL.

Verification
REQ-031 rst low 3 cycles, req=01 for one cycle -> start at cycle 1, a=b=1 and done=01 at cycle 2, txn_cnt=1.
REQ-032 req=11 held, GAP_CYCLES=2 -> grants alternate 01,10,01; start pulses every 5 cycles.
REQ-033 GAP_CYCLES=0, req=10 held -> start every 3 cycles, busy drops for one IDLE cycle between transactions.
REQ-034 rst pulled low in DRIVE -> all outputs 0 immediately, no done, txn_cnt unchanged.
REQ-035 CNT_W=2, 5 transactions -> txn_cnt sequence 1,2,3,0,1.
REQ-036 Assertion $rose(start) |-> ##1 (a&&b) and $onehot0(gnt) SHALL pass across all scenarios.

Source files
------------

// File: rtl/start_seq_pkg.sv
// ============================================================================
// Module : start_seq_pkg
// Brief  : Shared state encoding and defaults for the start/drive sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package start_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DRIVE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int unsigned GAP_CYCLES_DEFAULT = 2;
    localparam int unsigned GAP_W              = 4;

    // Pointer value 1 means requester 1 was granted last, so requester 0 wins first.
    localparam logic        PTR_RESET          = 1'b1;

endpackage : start_seq_pkg

`default_nettype wire

// File: rtl/start_seq_arb_rr.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-requester round-robin selector, purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win
);

    always_comb begin
        o_win = 2'b00;
        case (i_req)
            2'b01:   o_win = 2'b01;
            2'b10:   o_win = 2'b10;
            2'b11:   o_win = i_last ? 2'b01 : 2'b10;
            default: o_win = 2'b00;
        endcase
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/start_seq_arb.sv
// ============================================================================
// Module : start_seq_arb
// Brief  : Round-robin arbiter issuing a START/DRIVE sequence plus idle gap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module start_seq_arb
    import start_seq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic             start,
    output logic             a,
    output logic             b,
    output logic [1:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);

    // Down-counter is loaded one short so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [GAP_W-1:0] c_GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    state_e             r_state;
    logic [1:0]         r_gnt;
    logic               r_start;
    logic               r_a;
    logic               r_b;
    logic [1:0]         r_done;
    logic               r_busy;
    logic [CNT_W-1:0]   r_txn_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic               r_last;
    logic [1:0]         w_win;

    rr_arb2 u_rr_arb2 (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 2'b00;
            r_start   <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_done    <= 2'b00;
            r_busy    <= 1'b0;
            r_txn_cnt <= '0;
            r_gap     <= '0;
            r_last    <= PTR_RESET;
        end else begin
            r_start <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_done  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_state <= ST_START;
                        r_gnt   <= w_win;
                        r_last  <= w_win[1];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_DRIVE;
                    r_a     <= 1'b1;
                    r_b     <= 1'b1;
                    r_done  <= r_gnt;
                end
                ST_DRIVE: begin
                    r_gnt     <= 2'b00;
                    r_txn_cnt <= r_txn_cnt + CNT_W'(1);
                    if (GAP_CYCLES == 0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_GAP;
                        r_gap   <= c_GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign start   = r_start;
    assign a       = r_a;
    assign b       = r_b;
    assign done    = r_done;
    assign busy    = r_busy;
    assign txn_cnt = r_txn_cnt;

endmodule : start_seq_arb

`default_nettype wire

// File: tb/tb_start_seq_arb.sv
// ============================================================================
// Module : tb_start_seq_arb
// Brief  : Two configurations (gap 2 / 8-bit count, gap 0 / 2-bit count) vs. timeline model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_start_seq_arb;

    localparam int GAP0 = 2;
    localparam int CW0  = 8;
    localparam int GAP1 = 0;
    localparam int CW1  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;

    logic [1:0] gnt0, done0, gnt1, done1;
    logic       start0, a0, b0, busy0, start1, a1, b1, busy1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;
    logic [7:0] o0, o1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    start_seq_arb #(.GAP_CYCLES(GAP0), .CNT_W(CW0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .start(start0),
        .a(a0), .b(b0), .done(done0), .busy(busy0), .txn_cnt(cnt0)
    );

    start_seq_arb #(.GAP_CYCLES(GAP1), .CNT_W(CW1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .start(start1),
        .a(a1), .b(b1), .done(done1), .busy(busy1), .txn_cnt(cnt1)
    );

    assign o0 = {gnt0, start0, a0, b0, done0, busy0};
    assign o1 = {gnt1, start1, a1, b1, done1, busy1};

    // Model: each transaction is remembered by the cycle it was granted;
    // every output is a function of the distance from that cycle.
    typedef struct packed {
        logic       act;
        logic       last;
        int         t0;
        logic [1:0] win;
        int         cnt;
    } mdl_t;

    localparam mdl_t M_RST = '{act: 1'b0, last: 1'b1, t0: 0, win: 2'b00, cnt: 0};

    mdl_t m0 = M_RST;
    mdl_t m1 = M_RST;

    function automatic mdl_t step(mdl_t m, int gap, int cw, logic [1:0] r, int n);
        mdl_t nx;
        nx = m;
        if (m.act && n == m.t0 + 2)
            nx.cnt = (m.cnt + 1) % (1 << cw);
        if (!m.act || n >= m.t0 + 3 + gap) begin
            if (r != 2'b00) begin
                nx.act  = 1'b1;
                nx.t0   = n;
                nx.win  = (r == 2'b11) ? (m.last ? 2'b01 : 2'b10) : r;
                nx.last = nx.win[1];
            end else begin
                nx.act = 1'b0;
            end
        end
        return nx;
    endfunction

    function automatic logic [7:0] expect_out(mdl_t m, int gap, int n, logic rs);
        int k;
        logic [1:0] g, d;
        logic s, ab, bz;
        if (!rs || !m.act) return 8'h00;
        k  = n - m.t0;
        if (k < 0) return 8'h00;
        s  = (k == 0);
        ab = (k == 1);
        g  = (k <= 1) ? m.win : 2'b00;
        d  = ab ? m.win : 2'b00;
        bz = (k <= 1 + gap);
        return {g, s, ab, ab, d, bz};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0 <= M_RST;
            m1 <= M_RST;
        end else begin
            m0 <= step(m0, GAP0, CW0, req, cyc);
            m1 <= step(m1, GAP1, CW1, req, cyc);
        end
    end

    always @(negedge clk) begin
        chk("out0", int'(o0), int'(expect_out(m0, GAP0, cyc - 1, rst)));
        chk("cnt0", int'(cnt0), rst ? m0.cnt : 0);
        chk("out1", int'(o1), int'(expect_out(m1, GAP1, cyc - 1, rst)));
        chk("cnt1", int'(cnt1), rst ? m1.cnt : 0);
    end

    a_rose0: assert property (@(posedge clk) disable iff (!rst) $rose(start0) |-> ##1 (a0 && b0))
        else begin errors++; $display("FAIL a_rose0 start not followed by a&&b t=%0t", $time); end
    a_rose1: assert property (@(posedge clk) disable iff (!rst) $rose(start1) |-> ##1 (a1 && b1))
        else begin errors++; $display("FAIL a_rose1 start not followed by a&&b t=%0t", $time); end
    a_oh0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt0) && $onehot0(done0))
        else begin errors++; $display("FAIL a_oh0 gnt=%b done=%b", gnt0, done0); end
    a_oh1: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt1) && $onehot0(done1))
        else begin errors++; $display("FAIL a_oh1 gnt=%b done=%b", gnt1, done1); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int         ta[8], tb_[8];
    logic [1:0] ga[8], gb[8];
    int         na, nb, ns;
    logic       bsy[16];
    int         cn[16];

    initial begin
        // Reset held three cycles, then a single-cycle request from requester 0.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out0", int'(o0), 0);
        chk("rst_out1", int'(o1), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        rst = 1'b1;
        req = 2'b01;
        tick();
        chk("s1_start", int'({start0, gnt0}), 3'b101);
        req = 2'b00;
        tick();
        chk("s1_drive", int'({a0, b0, done0}), 4'b1101);
        chk("s1_drive1", int'({a1, b1, done1}), 4'b1101);
        tick();
        chk("s1_cnt0", int'(cnt0), 1);
        chk("s1_cnt1", int'(cnt1), 1);
        chk("s1_busy", int'({busy0, busy1}), 2'b10);
        tick();

        // Contention with both requesters held.
        pulse_reset();
        req = 2'b11;
        na = 0;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (start0 && na < 8) begin ta[na] = i; ga[na] = gnt0; na++; end
            if (start1 && nb < 8) begin tb_[nb] = i; gb[nb] = gnt1; nb++; end
        end
        chk("s2_nstart0", na, 4);
        chk("s2_g0_0", int'(ga[0]), 1);
        chk("s2_g0_1", int'(ga[1]), 2);
        chk("s2_g0_2", int'(ga[2]), 1);
        chk("s2_space0a", ta[1] - ta[0], 5);
        chk("s2_space0b", ta[2] - ta[1], 5);
        chk("s2_nstart1", nb, 6);
        chk("s2_g1_1", int'(gb[1]), 2);
        chk("s2_space1", tb_[1] - tb_[0], 3);

        // Requester 1 alone on the zero-gap instance, count wraps at 2 bits.
        req = 2'b00;
        pulse_reset();
        req = 2'b10;
        ns = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            bsy[i] = busy1;
            cn[i]  = int'(cnt1);
            if (start1) ns++;
        end
        chk("s3_nstart", ns, 6);
        chk("s3_busy1", int'(bsy[1]), 1);
        chk("s3_busy2", int'(bsy[2]), 0);
        chk("s3_busy3", int'(bsy[3]), 1);
        chk("s3_cnt_a", cn[2], 1);
        chk("s3_cnt_b", cn[5], 2);
        chk("s3_cnt_c", cn[8], 3);
        chk("s3_cnt_d", cn[11], 0);
        chk("s3_cnt_e", cn[14], 1);

        // Reset asserted while in DRIVE.
        req = 2'b00;
        pulse_reset();
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        chk("s4_indrive", int'(a0), 1);
        #1 rst = 1'b0;
        #1;
        chk("s4_async0", int'(o0), 0);
        chk("s4_async1", int'(o1), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("s4_cnt0", int'(cnt0), 0);
        chk("s4_done0", int'(done0), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 249) == 0) begin
                #1 rst = 1'b0;
                #1;
                chk("rnd_rst0", int'(o0), 0);
                chk("rnd_rst1", int'(o1), 0);
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_start_seq_arb

`default_nettype wire
